crack_sched: RTL and testbench

CRACK_SCHED -- requirements
Module: crack_sched

---
 rtl/crack_pkg.sv | 18 +
 rtl/crack_sched_if.sv | 47 ++++
 rtl/ct_rr_arb.sv | 57 +++++
 rtl/crack_sched.sv | 115 +++++++++++
 tb/tb_crack_sched.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/crack_pkg.sv
// Shared types and constants for the two-core key-search scheduler.
// Core i searches keys base_i, base_i + stride, base_i + 2*stride, ...
package crack_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    RUN,
    ABORT,
    DONE
  } state_e;

  localparam int NUM_CORES  = 2;
  localparam int KEY_BASE0  = 0;
  localparam int KEY_BASE1  = 1;
  localparam int KEY_STRIDE = 2;

endpackage

// File: rtl/crack_sched_if.sv
// Bundles the upstream handshake, core control, core memory and ct_mem
// signals of the scheduler; slave is the scheduler side.
interface crack_sched_if
  import crack_pkg::*;
#(
  parameter int KEY_W  = 24,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);

  logic                 en;
  logic                 rdy;
  logic [KEY_W-1:0]     key;
  logic                 key_valid;

  logic [NUM_CORES-1:0] c_en;
  logic [NUM_CORES-1:0] c_abort;
  logic [NUM_CORES-1:0] c_rdy;
  logic [KEY_W-1:0]     c_key0;
  logic [KEY_W-1:0]     c_key1;
  logic [NUM_CORES-1:0] c_key_valid;

  logic [NUM_CORES-1:0] c_req;
  logic [ADDR_W-1:0]    c_addr0;
  logic [ADDR_W-1:0]    c_addr1;
  logic [NUM_CORES-1:0] c_gnt;
  logic [NUM_CORES-1:0] c_rvalid;
  logic [DATA_W-1:0]    c_rddata;

  logic [ADDR_W-1:0]    ct_addr;
  logic [DATA_W-1:0]    ct_rddata;

  modport slave (
    input  en, c_rdy, c_key0, c_key1, c_key_valid,
    input  c_req, c_addr0, c_addr1, ct_rddata,
    output rdy, key, key_valid, c_en, c_abort,
    output c_gnt, c_rvalid, c_rddata, ct_addr
  );

  modport master (
    output en, c_rdy, c_key0, c_key1, c_key_valid,
    output c_req, c_addr0, c_addr1, ct_rddata,
    input  rdy, key, key_valid, c_en, c_abort,
    input  c_gnt, c_rvalid, c_rddata, ct_addr
  );

endinterface

// File: rtl/ct_rr_arb.sv
// Two-way round-robin arbiter for the shared ct_mem read port; grant is
// combinational so the address reaches the memory in the request cycle.
module ct_rr_arb
  import crack_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_CORES-1:0] req,
  input  logic [ADDR_W-1:0]    addr0,
  input  logic [ADDR_W-1:0]    addr1,
  output logic [NUM_CORES-1:0] gnt,
  output logic [NUM_CORES-1:0] rvalid,
  output logic [ADDR_W-1:0]    ct_addr
);

  logic                 rr_q, rr_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [NUM_CORES-1:0] rvalid_q;

  // rr_q == 0 favours core 0 on a collision; it flips to the loser after every grant.
  always_comb begin
    gnt    = '0;
    rr_d   = rr_q;
    addr_d = addr_q;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = rr_q ? 2'b10 : 2'b01;
      default: gnt = '0;
    endcase
    if (gnt[0]) begin
      rr_d   = 1'b1;
      addr_d = addr0;
    end else if (gnt[1]) begin
      rr_d   = 1'b0;
      addr_d = addr1;
    end
  end

  assign ct_addr = addr_d;
  assign rvalid  = rvalid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q     <= 1'b0;
      addr_q   <= '0;
      rvalid_q <= '0;
    end else begin
      rr_q     <= rr_d;
      addr_q   <= addr_d;
      rvalid_q <= gnt;
    end
  end

endmodule

// File: rtl/crack_sched.sv
// Launches two search cores, collects the first valid key, aborts the
// remaining core, and shares ct_mem between the cores via ct_rr_arb.
module crack_sched
  import crack_pkg::*;
#(
  parameter int KEY_W  = 24,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  crack_sched_if.slave  bus
);

  state_e               state_q, state_d;
  logic [KEY_W-1:0]     key_q, key_d;
  logic                 key_valid_q, key_valid_d;
  logic [NUM_CORES-1:0] c_en_q, c_en_d;
  logic [NUM_CORES-1:0] c_abort_q, c_abort_d;
  logic [NUM_CORES-1:0] fin_q, fin_d;
  logic [NUM_CORES-1:0] c_rdy_q;
  logic [NUM_CORES-1:0] rise;
  logic [DATA_W-1:0]    rd_data;

  assign rise = bus.c_rdy & ~c_rdy_q;

  // Core 0 is checked first so a simultaneous valid finish resolves to it.
  always_comb begin
    state_d     = state_q;
    key_d       = key_q;
    key_valid_d = key_valid_q;
    c_en_d      = '0;
    c_abort_d   = '0;
    fin_d       = fin_q;
    case (state_q)
      IDLE: begin
        if (bus.en) begin
          state_d     = LAUNCH;
          key_d       = '0;
          key_valid_d = 1'b0;
          fin_d       = '0;
        end
      end
      LAUNCH: begin
        if (bus.c_rdy == 2'b11) begin
          c_en_d  = 2'b11;
          state_d = RUN;
        end
      end
      RUN: begin
        fin_d = fin_q | rise;
        if (rise[0] && bus.c_key_valid[0]) begin
          key_d     = bus.c_key0;
          c_abort_d = ~bus.c_rdy;
          state_d   = ABORT;
        end else if (rise[1] && bus.c_key_valid[1]) begin
          key_d     = bus.c_key1;
          c_abort_d = ~bus.c_rdy;
          state_d   = ABORT;
        end else if (fin_d == 2'b11) begin
          state_d = DONE;
        end
      end
      ABORT: begin
        if (bus.c_rdy == 2'b11) begin
          key_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      key_q       <= '0;
      key_valid_q <= 1'b0;
      c_en_q      <= '0;
      c_abort_q   <= '0;
      fin_q       <= '0;
      c_rdy_q     <= '0;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      key_valid_q <= key_valid_d;
      c_en_q      <= c_en_d;
      c_abort_q   <= c_abort_d;
      fin_q       <= fin_d;
      c_rdy_q     <= bus.c_rdy;
    end
  end

  assign bus.rdy       = (state_q == IDLE);
  assign bus.key       = key_q;
  assign bus.key_valid = key_valid_q;
  assign bus.c_en      = c_en_q;
  assign bus.c_abort   = c_abort_q;

  assign rd_data      = bus.ct_rddata;
  assign bus.c_rddata = rd_data;

  ct_rr_arb #(.ADDR_W(ADDR_W)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (bus.c_req),
    .addr0   (bus.c_addr0),
    .addr1   (bus.c_addr1),
    .gnt     (bus.c_gnt),
    .rvalid  (bus.c_rvalid),
    .ct_addr (bus.ct_addr)
  );

endmodule

// File: tb/tb_crack_sched.sv
// Scoreboard bench for crack_sched: stimulus pushes expected pulses/results,
// a negedge monitor pops and compares whenever the DUT presents one.
module tb_crack_sched;

  localparam int KEY_W  = 24;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  crack_sched_if #(.KEY_W(KEY_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  crack_sched #(.KEY_W(KEY_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // ct_mem model: one-cycle latency, contents = address ^ 8'hB5.
  always @(posedge clk) bus.ct_rddata <= bus.ct_addr ^ 8'hB5;

  int checks = 0;
  int errors = 0;

  logic [1:0]  exp_en_q[$];
  logic [1:0]  exp_abort_q[$];
  logic [24:0] exp_res_q[$];
  logic [9:0]  exp_gnt_q[$];
  logic [9:0]  exp_rd_q[$];
  logic        rdy_prev = 1'b1;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every visible DUT event must match the head of its queue.
  always @(negedge clk) begin
    if (!rst_n) begin
      rdy_prev = 1'b1;
    end else begin
      if (bus.c_en != 2'b00) begin
        if (exp_en_q.size() == 0) check_output("c_en_unexpected", 64'(bus.c_en), 64'd0);
        else check_output("c_en", 64'(bus.c_en), 64'(exp_en_q.pop_front()));
      end
      if (bus.c_abort != 2'b00) begin
        if (exp_abort_q.size() == 0) check_output("c_abort_unexpected", 64'(bus.c_abort), 64'd0);
        else check_output("c_abort", 64'(bus.c_abort), 64'(exp_abort_q.pop_front()));
      end
      if (bus.c_gnt != 2'b00) begin
        if (exp_gnt_q.size() == 0) check_output("gnt_unexpected", 64'(bus.c_gnt), 64'd0);
        else check_output("gnt_addr", 64'({bus.c_gnt, bus.ct_addr}), 64'(exp_gnt_q.pop_front()));
      end
      if (bus.c_rvalid != 2'b00) begin
        if (exp_rd_q.size() == 0) check_output("rvalid_unexpected", 64'(bus.c_rvalid), 64'd0);
        else check_output("rvalid_data", 64'({bus.c_rvalid, bus.c_rddata}), 64'(exp_rd_q.pop_front()));
      end
      if (bus.rdy && !rdy_prev) begin
        if (exp_res_q.size() == 0) check_output("result_unexpected", 64'({bus.key_valid, bus.key}), 64'h1FFFFFF);
        else check_output("result", 64'({bus.key_valid, bus.key}), 64'(exp_res_q.pop_front()));
      end
      rdy_prev = bus.rdy;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [1:0] rdy, input logic [1:0] kv,
                                input logic [23:0] k0, input logic [23:0] k1);
    bus.c_rdy       = rdy;
    bus.c_key_valid = kv;
    bus.c_key0      = k0;
    bus.c_key1      = k1;
    tick();
  endtask

  // Issue en, wait (bounded) for the launch pulse, then make both cores busy.
  task automatic start_run();
    bit seen;
    seen = 1'b0;
    exp_en_q.push_back(2'b11);
    bus.en = 1'b1;
    tick();
    bus.en = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (bus.c_en == 2'b11) seen = 1'b1;
    end
    if (!seen) check_output("c_en_timeout", 64'(bus.c_en), 64'd3);
    check_output("rdy_busy", 64'(bus.rdy), 64'd0);
    tick();
    apply_stimulus(2'b00, 2'b00, 24'h0, 24'h0);
    check_output("rdy_running", 64'(bus.rdy), 64'd0);
  endtask

  task automatic wait_idle();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus.rdy) seen = 1'b1;
    end
    if (!seen) check_output("rdy_timeout", 64'(bus.rdy), 64'd1);
    tick();
  endtask

  task automatic check_reset_values();
    check_output("rst_rdy", 64'(bus.rdy), 64'd1);
    check_output("rst_key", 64'(bus.key), 64'd0);
    check_output("rst_key_valid", 64'(bus.key_valid), 64'd0);
    check_output("rst_c_en", 64'(bus.c_en), 64'd0);
    check_output("rst_c_abort", 64'(bus.c_abort), 64'd0);
    check_output("rst_c_rvalid", 64'(bus.c_rvalid), 64'd0);
    check_output("rst_ct_addr", 64'(bus.ct_addr), 64'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.en          = 1'b0;
    bus.c_rdy       = 2'b11;
    bus.c_key_valid = 2'b00;
    bus.c_key0      = '0;
    bus.c_key1      = '0;
    bus.c_req       = 2'b00;
    bus.c_addr0     = '0;
    bus.c_addr1     = '0;
    repeat (3) tick();
    check_reset_values();
    rst_n = 1'b1;
    tick();

    // Case 1 + 2: launch, core1 finishes with 0x0B while core0 busy.
    start_run();
    apply_stimulus(2'b00, 2'b00, 24'h0, 24'h0);
    exp_abort_q.push_back(2'b01);
    exp_res_q.push_back({1'b1, 24'h00000B});
    apply_stimulus(2'b10, 2'b10, 24'h0, 24'h00000B);
    apply_stimulus(2'b10, 2'b00, 24'h0, 24'h00000B);
    apply_stimulus(2'b11, 2'b00, 24'h0, 24'h0);
    wait_idle();
    check_output("case2_key_held", 64'(bus.key), 64'h00000B);

    // Case 3: simultaneous valid finishes resolve to core 0.
    start_run();
    exp_res_q.push_back({1'b1, 24'h000010});
    apply_stimulus(2'b11, 2'b11, 24'h000010, 24'h000011);
    apply_stimulus(2'b11, 2'b00, 24'h0, 24'h0);
    wait_idle();

    // Case 4: both cores finish (staggered) without a key.
    start_run();
    exp_res_q.push_back({1'b0, 24'h000000});
    apply_stimulus(2'b01, 2'b00, 24'h0, 24'h0);
    apply_stimulus(2'b01, 2'b00, 24'h0, 24'h0);
    apply_stimulus(2'b11, 2'b00, 24'h0, 24'h0);
    wait_idle();
    check_output("case4_rdy", 64'(bus.rdy), 64'd1);

    // Single core0 request moves rr towards core 1 before the reset test.
    exp_gnt_q.push_back({2'b01, 8'h33});
    exp_rd_q.push_back({2'b01, 8'h86});
    bus.c_req   = 2'b01;
    bus.c_addr0 = 8'h33;
    tick();
    bus.c_req = 2'b00;
    repeat (2) tick();

    // Case 6: reset in the middle of a run.
    start_run();
    tick();
    rst_n = 1'b0;
    #1;
    check_reset_values();
    bus.c_rdy = 2'b11;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Case 5: both cores request for four cycles; rr restarts at core 0.
    bus.c_req   = 2'b11;
    bus.c_addr0 = 8'h10;
    bus.c_addr1 = 8'h20;
    for (int i = 0; i < 2; i++) begin
      exp_gnt_q.push_back({2'b01, 8'h10});
      exp_rd_q.push_back({2'b01, 8'hA5});
      exp_gnt_q.push_back({2'b10, 8'h20});
      exp_rd_q.push_back({2'b10, 8'h95});
    end
    repeat (4) tick();
    bus.c_req = 2'b00;
    repeat (2) tick();
    check_output("ct_addr_hold", 64'(bus.ct_addr), 64'h20);

    // Clean run after reset: core0 finds 0x05 while core1 busy.
    start_run();
    exp_abort_q.push_back(2'b10);
    exp_res_q.push_back({1'b1, 24'h000005});
    apply_stimulus(2'b01, 2'b01, 24'h000005, 24'h0);
    apply_stimulus(2'b01, 2'b00, 24'h000005, 24'h0);
    apply_stimulus(2'b11, 2'b00, 24'h0, 24'h0);
    wait_idle();

    // Lone core1 request is granted in the same cycle.
    exp_gnt_q.push_back({2'b10, 8'h44});
    exp_rd_q.push_back({2'b10, 8'hF1});
    bus.c_req   = 2'b10;
    bus.c_addr1 = 8'h44;
    tick();
    bus.c_req = 2'b00;
    repeat (3) tick();

    check_output("en_queue_left", 64'(exp_en_q.size()), 64'd0);
    check_output("abort_queue_left", 64'(exp_abort_q.size()), 64'd0);
    check_output("result_queue_left", 64'(exp_res_q.size()), 64'd0);
    check_output("gnt_queue_left", 64'(exp_gnt_q.size()), 64'd0);
    check_output("rd_queue_left", 64'(exp_rd_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
